// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response bus between the MEM stage and the memory access unit
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        mem_write;
   logic [2:0]  mem_op;
   logic        load_sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output req_valid, mem_write, mem_op, load_sign, addr, wdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, mem_write, mem_op, load_sign, addr, wdata,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage byte/half/word access unit over a word-wide RAM, sub-word stores by read-modify-write
// Optional alignment checking: MEMACC_ALIGN_CHECK_EN
module mem_access_unit #(
   parameter int RAM_AW = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.slave  bus,
   output logic              stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam logic [2:0] OP_B = 3'b001;
   localparam logic [2:0] OP_H = 3'b010;
   localparam logic [2:0] OP_W = 3'b100;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_LD, S_MRG} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [RAM_AW+1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [2:0]          r_op;
   logic                r_we;
   logic                r_sign;
   logic                r_rsp_valid;
   logic                r_rsp_err;
   logic [31:0]         r_rsp_data;

   logic                w_accept;
   logic                w_op_bad;
   logic                w_misalign;
   logic                w_req_err;
   logic                w_err_accept;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load_ext;
   logic [31:0]         w_merge;

   assign w_accept = bus.req_valid && (r_state == S_IDLE);
   assign w_op_bad = !((bus.mem_op == OP_B) || (bus.mem_op == OP_H) || (bus.mem_op == OP_W));
`ifdef MEMACC_ALIGN_CHECK_EN
   assign w_misalign = ((bus.mem_op == OP_H) && bus.addr[0]) ||
                       ((bus.mem_op == OP_W) && (bus.addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif
   assign w_req_err    = w_op_bad || w_misalign;
   assign w_err_accept = w_accept && w_req_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_req_err) begin
               w_next = (bus.mem_write && (bus.mem_op == OP_W)) ? S_WR : S_RD;
            end
         end
         S_RD:    w_next = r_we ? S_MRG : S_LD;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (r_state == S_IDLE);
      stall         = (r_state != S_IDLE);
      ram_en        = (r_state == S_RD) || (r_state == S_WR) || (r_state == S_MRG);
      ram_we        = (r_state == S_WR) || (r_state == S_MRG);
      ram_wdata     = (r_state == S_MRG) ? w_merge : r_wdata;
   end

   assign ram_addr = r_addr[RAM_AW+1:2];

   // Lane extraction for loads and lane replacement for the RMW write both key off the latched address.
   always_comb begin
      w_byte = 8'h00;
      case (r_addr[1:0])
         2'd0:    w_byte = ram_rdata[7:0];
         2'd1:    w_byte = ram_rdata[15:8];
         2'd2:    w_byte = ram_rdata[23:16];
         default: w_byte = ram_rdata[31:24];
      endcase
      w_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      w_load_ext = ram_rdata;
      if (r_op == OP_B) begin
         w_load_ext = r_sign ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      end else if (r_op == OP_H) begin
         w_load_ext = r_sign ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
      end
      w_merge = ram_rdata;
      if (r_op == OP_B) begin
         w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end else if (r_op == OP_H) begin
         w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_op    <= '0;
         r_we    <= 1'b0;
         r_sign  <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= bus.addr[RAM_AW+1:0];
         r_wdata <= bus.wdata;
         r_op    <= bus.mem_op;
         r_we    <= bus.mem_write;
         r_sign  <= bus.load_sign;
      end
   end

   // Completion pulses in the IDLE cycle following the last access cycle, or right after an error accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= w_err_accept || (r_state == S_LD) || (r_state == S_MRG) || (r_state == S_WR);
         r_rsp_err   <= w_err_accept;
         if (r_state == S_LD) begin
            r_rsp_data <= w_load_ext;
         end else if (w_err_accept || (r_state == S_MRG) || (r_state == S_WR)) begin
            r_rsp_data <= '0;
         end
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural synchronous RAM
module tb_mem_access_unit;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
      time         t_acc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        ram_en;
   logic        ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:1023];
   logic        pl_we;
   logic [9:0]  pl_addr;
   logic [31:0] pl_data;

   int n_chk;
   int n_fail;
   int en_cnt;
   int we_cnt;
   int rsp_cnt;
   exp_t q[$];

   mem_access_unit_if bus();

   mem_access_unit #(.RAM_AW(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .stall     (stall),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
      if (ram_en) en_cnt <= en_cnt + 1;
      if (ram_en && ram_we) we_cnt <= we_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid) begin
         rsp_cnt <= rsp_cnt + 1;
         if (q.size() == 0) begin
            chk("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_err", bus.rsp_err, e.err);
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_latency", int'(($time - e.t_acc + 5) / 10), e.lat);
         end
      end
   end

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic issue(input logic wr, input logic [2:0] op, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic push,
                        input logic e_err, input logic [31:0] e_data, input int lat);
      @(negedge clk);
      chk("req_ready_at_issue", bus.req_ready, 32'd1);
      bus.mem_write = wr; bus.mem_op = op; bus.load_sign = sg;
      bus.addr = a; bus.wdata = wd; bus.req_valid = 1'b1;
      @(posedge clk);
      if (push) q.push_back('{e_err, e_data, lat, $time});
      #1;
      bus.req_valid = 1'b0; bus.mem_write = ~wr; bus.mem_op = 3'b111;
      bus.load_sign = ~sg; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'h5A5A_5A5A;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", q.size(), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int en0;
      int we0;
      int rsp0;
      int exp_en;
      n_chk = 0; n_fail = 0; en_cnt = 0; we_cnt = 0; rsp_cnt = 0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0; ram_rdata = '0;
      bus.req_valid = 1'b0; bus.mem_write = 1'b0; bus.mem_op = 3'b000;
      bus.load_sign = 1'b0; bus.addr = '0; bus.wdata = '0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 32'd1);
      chk("rst_stall", stall, 32'd0);
      chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
      chk("rst_rsp_err", bus.rsp_err, 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_ram_en", ram_en, 32'd0);
      chk("rst_ram_we", ram_we, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // word store: single WR cycle
      issue(1'b1, 3'b100, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 2);
      @(negedge clk);
      chk("wst_ram_en", ram_en, 32'd1);
      chk("wst_ram_we", ram_we, 32'd1);
      chk("wst_ram_addr", ram_addr, 32'd4);
      chk("wst_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
      wait_done();
      chk("wst_mem4", mem[4], 32'hDEAD_BEEF);

      // loads with extension
      preload(10'd4, 32'h80FF_0000);
      issue(1'b0, 3'b001, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 3);
      wait_done();
      issue(1'b0, 3'b001, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 3);
      wait_done();
      issue(1'b0, 3'b001, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 3);
      wait_done();
      issue(1'b0, 3'b010, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000_80FF, 3);
      wait_done();
      issue(1'b0, 3'b100, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 32'h80FF_0000, 3);
      wait_done();

      // half store RMW
      preload(10'd4, 32'hAABB_CCDD);
      issue(1'b1, 3'b010, 1'b0, 32'h12, 32'h0000_1234, 1'b1, 1'b0, 32'h0, 3);
      @(negedge clk);
      chk("hst_rd_en", ram_en, 32'd1);
      chk("hst_rd_we", ram_we, 32'd0);
      @(negedge clk);
      chk("hst_mrg_we", ram_we, 32'd1);
      chk("hst_mrg_wdata", ram_wdata, 32'h1234_CCDD);
      wait_done();
      chk("hst_mem4", mem[4], 32'h1234_CCDD);

      issue(1'b1, 3'b001, 1'b0, 32'h11, 32'h0000_0055, 1'b1, 1'b0, 32'h0, 3);
      wait_done();
      chk("bst_mem4", mem[4], 32'h1234_55DD);

      // misaligned half load
      preload(10'd4, 32'hAABB_CCDD);
      en0 = en_cnt;
`ifdef MEMACC_ALIGN_CHECK_EN
      exp_en = 0;
      issue(1'b0, 3'b010, 1'b1, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0, 1);
`else
      exp_en = 1;
      issue(1'b0, 3'b010, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0, 32'hFFFF_CCDD, 3);
`endif
      wait_done();
      chk("misalign_ram_en_cycles", en_cnt - en0, exp_en);

      // illegal mem_op: no RAM access
      en0 = en_cnt;
      issue(1'b0, 3'b011, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0, 1);
      wait_done();
      chk("err_ram_en_cycles", en_cnt - en0, 32'd0);

      // error followed by a request accepted in the rsp_valid cycle
      issue(1'b1, 3'b000, 1'b0, 32'h10, 32'h1, 1'b1, 1'b1, 32'h0, 1);
      issue(1'b0, 3'b100, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hAABB_CCDD, 3);
      wait_done();

      // reset during the RD cycle of a byte store
      preload(10'd8, 32'h1122_3344);
      we0 = we_cnt;
      rsp0 = rsp_cnt;
      issue(1'b1, 3'b001, 1'b0, 32'h20, 32'h0000_00EE, 1'b0, 1'b0, 32'h0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ram_en", ram_en, 32'd0);
      chk("rst_mid_ram_we", ram_we, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_mid_we_cycles", we_cnt - we0, 32'd0);
      chk("rst_mid_mem8", mem[8], 32'h1122_3344);
      chk("rst_mid_req_ready", bus.req_ready, 32'd1);
      chk("rst_mid_rsp_count", rsp_cnt - rsp0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
